// File: rtl/pcie_us_rq_tag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_us_rq_tag_pkg
//  Description : Shared types and constants for the PCIe UltraScale RQ tag
//                manager (per-tag state encoding, legal tag widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package pcie_us_rq_tag_pkg;

    // Lifecycle of a single requester tag
    typedef enum logic [1:0] {
        TAG_FREE      = 2'd0,
        TAG_BUSY      = 2'd1,
        TAG_TIMED_OUT = 2'd2
    } tag_state_t;

    // Supported tag-space sizes: 32, 64 and 256 tags
    localparam int c_tag_width_32  = 5;
    localparam int c_tag_width_64  = 6;
    localparam int c_tag_width_256 = 8;

    // True when w names one of the supported tag-space sizes
    function automatic logic tag_width_legal(input int w);
        return (w == c_tag_width_32) || (w == c_tag_width_64) || (w == c_tag_width_256);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_us_rq_tag_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_us_rq_tag_prio_enc
//  Description : Lowest-set-bit priority encoder; returns the index of the
//                lowest asserted bit and a flag saying any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_us_rq_tag_prio_enc #(
    parameter int WIDTH     = 64,
    parameter int IDX_WIDTH = 6
) (
    input  logic [WIDTH-1:0]     i_vec,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IDX_WIDTH'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcie_us_rq_tag_mgr.sv
`default_nettype none
// ============================================================================
//  Module      : pcie_us_rq_tag_mgr
//  Description : Requester tag manager for the UltraScale PCIe RQ/RC user
//                interface. Hands out tags for non-posted requests when NPH
//                credit is available, frees them on the final completion and
//                reports tags whose completion never arrived (scanned
//                timestamp table, one tag per cycle).
//                Optional statistics counters: PCIE_US_RQ_TAG_MGR_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcie_us_rq_tag_mgr
    import pcie_us_rq_tag_pkg::*;
#(
    parameter int TAG_WIDTH      = 6,
    parameter int TIMEOUT_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 250000
) (
    input  logic                 user_clk,
    input  logic                 user_reset,
    input  logic                 enable,
    input  logic [1:0]           pcie_tfc_nph_av,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 cpl_valid,
    input  logic [TAG_WIDTH-1:0] cpl_tag,
    input  logic                 cpl_last,
    output logic                 cpl_err,
    output logic                 timeout_valid,
    output logic [TAG_WIDTH-1:0] timeout_tag,
    input  logic                 timeout_ready,
    output logic [TAG_WIDTH:0]   outstanding_count
`ifdef PCIE_US_RQ_TAG_MGR_STATS_EN
    ,
    output logic [31:0]          stat_alloc_count,
    output logic [31:0]          stat_timeout_count,
    output logic [31:0]          stat_cpl_err_count
`endif
);

    localparam int                     c_num_tags = 1 << TAG_WIDTH;
    localparam logic [TIMEOUT_WIDTH-1:0] c_timeout = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    tag_state_t                 r_state [c_num_tags];
    logic [TIMEOUT_WIDTH-1:0]   r_stamp [c_num_tags];
    logic [TIMEOUT_WIDTH-1:0]   r_time;
    logic [TAG_WIDTH-1:0]       r_scan_ptr;
    logic                       r_alloc_en;
    logic                       r_rpt_valid;
    logic [TAG_WIDTH-1:0]       r_rpt_tag;
    logic                       r_cpl_err;
    logic [TAG_WIDTH:0]         r_count;

    logic [c_num_tags-1:0]      w_free_vec;
    logic [TAG_WIDTH-1:0]       w_free_idx;
    logic                       w_any_free;
    logic                       w_alloc;
    tag_state_t                 w_cpl_state;
    logic                       w_cpl_free;
    logic                       w_cpl_err_nxt;
    logic [TIMEOUT_WIDTH-1:0]   w_elapsed;
    logic                       w_scan_hit;
    logic                       w_rpt_free;

    // FREE vector decoded from registered per-tag state
    always_comb begin
        w_free_vec = '0;
        for (int i = 0; i < c_num_tags; i++) begin
            w_free_vec[i] = (r_state[i] == TAG_FREE);
        end
    end

    pcie_us_rq_tag_prio_enc #(
        .WIDTH     (c_num_tags),
        .IDX_WIDTH (TAG_WIDTH)
    ) u_free_enc (
        .i_vec   (w_free_vec),
        .o_idx   (w_free_idx),
        .o_valid (w_any_free)
    );

    // r_alloc_en keeps req_ready low during the cycle that follows a reset edge
    assign req_ready = r_alloc_en && enable && (pcie_tfc_nph_av != 2'b00) && w_any_free;
    assign req_tag   = w_free_idx;
    assign w_alloc   = req_valid && req_ready;

    // Completion decode: only a final completion on a BUSY tag frees it
    assign w_cpl_state   = r_state[cpl_tag];
    assign w_cpl_free    = cpl_valid && cpl_last && (w_cpl_state == TAG_BUSY);
    assign w_cpl_err_nxt = cpl_valid && (w_cpl_state != TAG_BUSY);

    // Timeout scan; modular subtraction tolerates time-counter wrap.
    // A final completion on the scanned tag in the same cycle takes priority.
    assign w_elapsed  = r_time - r_stamp[r_scan_ptr];
    assign w_scan_hit = !r_rpt_valid
                     && (r_state[r_scan_ptr] == TAG_BUSY)
                     && (w_elapsed >= c_timeout)
                     && !(w_cpl_free && (cpl_tag == r_scan_ptr));
    assign w_rpt_free = r_rpt_valid && timeout_ready;

    // Per-tag state and timestamp table; the four updates always target distinct tags
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            for (int i = 0; i < c_num_tags; i++) begin
                r_state[i] <= TAG_FREE;
                r_stamp[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_state[w_free_idx] <= TAG_BUSY;
                r_stamp[w_free_idx] <= r_time;
            end
            if (w_cpl_free) begin
                r_state[cpl_tag] <= TAG_FREE;
            end
            if (w_scan_hit) begin
                r_state[r_scan_ptr] <= TAG_TIMED_OUT;
            end
            if (w_rpt_free) begin
                r_state[r_rpt_tag] <= TAG_FREE;
            end
        end
    end

    // Time base, scan pointer (stalls while a report is pending), report register, counters
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_time      <= '0;
            r_scan_ptr  <= '0;
            r_alloc_en  <= 1'b0;
            r_rpt_valid <= 1'b0;
            r_rpt_tag   <= '0;
            r_cpl_err   <= 1'b0;
            r_count     <= '0;
        end else begin
            r_time     <= r_time + 1'b1;
            r_alloc_en <= 1'b1;
            r_cpl_err  <= w_cpl_err_nxt;
            if (!r_rpt_valid) begin
                r_scan_ptr <= r_scan_ptr + 1'b1;
            end
            if (w_scan_hit) begin
                r_rpt_valid <= 1'b1;
                r_rpt_tag   <= r_scan_ptr;
            end else if (w_rpt_free) begin
                r_rpt_valid <= 1'b0;
            end
            r_count <= r_count + (TAG_WIDTH+1)'(w_alloc)
                               - (TAG_WIDTH+1)'(w_cpl_free)
                               - (TAG_WIDTH+1)'(w_rpt_free);
        end
    end

    assign cpl_err           = r_cpl_err;
    assign timeout_valid     = r_rpt_valid;
    assign timeout_tag       = r_rpt_tag;
    assign outstanding_count = r_count;

`ifdef PCIE_US_RQ_TAG_MGR_STATS_EN
    localparam logic [31:0] c_stat_max = 32'hFFFF_FFFF;

    logic [31:0] r_stat_alloc;
    logic [31:0] r_stat_timeout;
    logic [31:0] r_stat_cpl_err;

    // Saturating event counters: handshakes, timeout reports, cpl_err pulses
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_stat_alloc   <= '0;
            r_stat_timeout <= '0;
            r_stat_cpl_err <= '0;
        end else begin
            if (w_alloc && (r_stat_alloc != c_stat_max)) begin
                r_stat_alloc <= r_stat_alloc + 32'd1;
            end
            if (w_scan_hit && (r_stat_timeout != c_stat_max)) begin
                r_stat_timeout <= r_stat_timeout + 32'd1;
            end
            if (r_cpl_err && (r_stat_cpl_err != c_stat_max)) begin
                r_stat_cpl_err <= r_stat_cpl_err + 32'd1;
            end
        end
    end

    assign stat_alloc_count   = r_stat_alloc;
    assign stat_timeout_count = r_stat_timeout;
    assign stat_cpl_err_count = r_stat_cpl_err;
`endif

endmodule
`default_nettype wire
